// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: ALU opcodes it decodes, widths,
// FSM state encoding and small opcode-classification helpers.
package mem_stage_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 8;

  localparam logic [ALU_OP_W-1:0] ALU_NOP  = 8'h00;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 8'h01;
  localparam logic [ALU_OP_W-1:0] ALU_LDB  = 8'h20;
  localparam logic [ALU_OP_W-1:0] ALU_LDBU = 8'h21;
  localparam logic [ALU_OP_W-1:0] ALU_LDH  = 8'h22;
  localparam logic [ALU_OP_W-1:0] ALU_LDHU = 8'h23;
  localparam logic [ALU_OP_W-1:0] ALU_LDW  = 8'h24;
  localparam logic [ALU_OP_W-1:0] ALU_STB  = 8'h28;
  localparam logic [ALU_OP_W-1:0] ALU_STH  = 8'h29;
  localparam logic [ALU_OP_W-1:0] ALU_STW  = 8'h2A;

  typedef enum logic [1:0] {
    MEM_STATE_IDLE = 2'd0,
    MEM_STATE_REQ  = 2'd1,
    MEM_STATE_WAIT = 2'd2,
    MEM_STATE_DONE = 2'd3
  } mem_state_e;

  function automatic logic is_load(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_LDB) || (op == ALU_LDBU) || (op == ALU_LDH) ||
           (op == ALU_LDHU) || (op == ALU_LDW);
  endfunction

  function automatic logic is_store(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_STB) || (op == ALU_STH) || (op == ALU_STW);
  endfunction

  // Halfword accesses need a 2-byte boundary, word accesses a 4-byte one.
  function automatic logic is_misaligned(input logic [ALU_OP_W-1:0] op,
                                         input logic [1:0]          off);
    if (op == ALU_LDH || op == ALU_LDHU || op == ALU_STH) return off[0];
    if (op == ALU_LDW || op == ALU_STW)                   return |off;
    return 1'b0;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load alignment: picks the addressed byte/half out of a 32-bit word and
// sign- or zero-extends it according to the load opcode.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0]         word,
  input  logic [1:0]          off,
  input  logic [ALU_OP_W-1:0] aluop,
  output logic [31:0]         data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension chosen by opcode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case leaves it unassigned and infers a latch.
    data     = word;
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (aluop)
      ALU_LDB:  data = {{24{byte_sel[7]}}, byte_sel};
      ALU_LDBU: data = {24'h0, byte_sel};
      ALU_LDH:  data = {{16{half_sel[15]}}, half_sel};
      ALU_LDHU: data = {16'h0, half_sel};
      default:  data = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores to the data RAM through a
// valid/ready request and a completion strobe, stalls the pipeline until
// the access finishes, and hands the aligned result to mem_wb.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            pause,
  input  logic [DATA_W-1:0]     mem_reg_write_data,
  input  logic [REG_ADDR_W-1:0] mem_reg_write_addr,
  input  logic                  mem_reg_write_en,
  input  logic [ALU_OP_W-1:0]   mem_aluop,
  input  logic [ADDR_W-1:0]     mem_mem_addr,
  input  logic [DATA_W-1:0]     mem_store_data,
  output logic                  dram_req_valid,
  input  logic                  dram_req_ready,
  output logic                  dram_we,
  output logic [ADDR_W-1:0]     dram_addr,
  output logic [3:0]            dram_wstrb,
  output logic [DATA_W-1:0]     dram_wdata,
  input  logic                  dram_resp_valid,
  input  logic [DATA_W-1:0]     dram_rdata,
  output logic [DATA_W-1:0]     wb_reg_write_data,
  output logic [REG_ADDR_W-1:0] wb_reg_write_addr,
  output logic                  wb_reg_write_en,
  output logic                  pause_request_mem,
  output logic                  excp_ale,
  output logic [ADDR_W-1:0]     excp_badv
);

  mem_state_e        state_q, state_d;
  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [3:0]        req_wstrb_q, req_wstrb_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0] load_buf_q, load_buf_d;

  logic              op_load, op_store, op_misalign, op_valid;
  logic [1:0]        off;
  logic [3:0]        st_wstrb;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] load_data;
  logic              unused_pause;

  // Only bit 4 (MEM held) matters to this stage.
  assign unused_pause = ^{pause[5], pause[3:0]};

  assign off         = mem_mem_addr[1:0];
  assign op_load     = is_load(mem_aluop);
  assign op_store    = is_store(mem_aluop);
  assign op_misalign = is_misaligned(mem_aluop, off);
  assign op_valid    = (op_load || op_store) && !op_misalign;

  // Store byte enables and lane-replicated store data.
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = mem_store_data;
    case (mem_aluop)
      ALU_STB: begin
        st_wstrb = 4'b0001 << off;
        st_wdata = {4{mem_store_data[7:0]}};
      end
      ALU_STH: begin
        st_wstrb = off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{mem_store_data[15:0]}};
      end
      ALU_STW: st_wstrb = 4'b1111;
      default: ;
    endcase
  end

  // Request FSM: capture request fields on IDLE->REQ, load word on WAIT->DONE.
  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wstrb_d = req_wstrb_q;
    req_wdata_d = req_wdata_q;
    load_buf_d  = load_buf_q;
    case (state_q)
      MEM_STATE_IDLE: if (op_valid) begin
        state_d     = MEM_STATE_REQ;
        req_we_d    = op_store;
        req_addr_d  = {mem_mem_addr[ADDR_W-1:2], 2'b00};
        req_wstrb_d = st_wstrb;
        req_wdata_d = st_wdata;
      end
      MEM_STATE_REQ:  if (dram_req_ready) state_d = MEM_STATE_WAIT;
      MEM_STATE_WAIT: if (dram_resp_valid) begin
        state_d    = MEM_STATE_DONE;
        load_buf_d = dram_rdata;
      end
      MEM_STATE_DONE: if (!pause[4]) state_d = MEM_STATE_IDLE;
      default:        state_d = MEM_STATE_IDLE;
    endcase
  end

  // State and request registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= MEM_STATE_IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wstrb_q <= 4'b0000;
      req_wdata_q <= '0;
      load_buf_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wstrb_q <= req_wstrb_d;
      req_wdata_q <= req_wdata_d;
      load_buf_q  <= load_buf_d;
    end
  end

  load_align u_load_align (
    .word  (load_buf_q),
    .off   (off),
    .aluop (mem_aluop),
    .data  (load_data)
  );

  assign dram_req_valid    = (state_q == MEM_STATE_REQ);
  assign dram_we           = req_we_q;
  assign dram_addr         = req_addr_q;
  assign dram_wstrb        = req_wstrb_q;
  assign dram_wdata        = req_wdata_q;
  assign pause_request_mem = op_valid && (state_q != MEM_STATE_DONE);
  assign excp_ale          = op_misalign;
  assign excp_badv         = op_misalign ? mem_mem_addr : '0;

  // Writeback: loads return aligned data, stores and faults never write.
  always_comb begin
    wb_reg_write_data = mem_reg_write_data;
    wb_reg_write_addr = mem_reg_write_addr;
    wb_reg_write_en   = mem_reg_write_en;
    if (op_misalign || op_store) wb_reg_write_en = 1'b0;
    else if (op_load)            wb_reg_write_data = load_data;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load/store sequences with a
// scoreboard of expected request fields and writeback results.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic        wb_en;
    logic [31:0] wb_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  pause_vec;
  logic [31:0] mem_reg_write_data;
  logic [4:0]  mem_reg_write_addr;
  logic        mem_reg_write_en;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_store_data;
  logic        dram_req_valid, dram_req_ready, dram_we;
  logic [31:0] dram_addr, dram_wdata, dram_rdata;
  logic [3:0]  dram_wstrb;
  logic        dram_resp_valid;
  logic [31:0] wb_reg_write_data;
  logic [4:0]  wb_reg_write_addr;
  logic        wb_reg_write_en, pause_request_mem, excp_ale;
  logic [31:0] excp_badv;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk                (clk),
    .rst                (rst),
    .pause              (pause_vec),
    .mem_reg_write_data (mem_reg_write_data),
    .mem_reg_write_addr (mem_reg_write_addr),
    .mem_reg_write_en   (mem_reg_write_en),
    .mem_aluop          (mem_aluop),
    .mem_mem_addr       (mem_mem_addr),
    .mem_store_data     (mem_store_data),
    .dram_req_valid     (dram_req_valid),
    .dram_req_ready     (dram_req_ready),
    .dram_we            (dram_we),
    .dram_addr          (dram_addr),
    .dram_wstrb         (dram_wstrb),
    .dram_wdata         (dram_wdata),
    .dram_resp_valid    (dram_resp_valid),
    .dram_rdata         (dram_rdata),
    .wb_reg_write_data  (wb_reg_write_data),
    .wb_reg_write_addr  (wb_reg_write_addr),
    .wb_reg_write_en    (wb_reg_write_en),
    .pause_request_mem  (pause_request_mem),
    .excp_ale           (excp_ale),
    .excp_badv          (excp_badv)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] wdata);
    mem_aluop          = op;
    mem_mem_addr       = addr;
    mem_store_data     = sdata;
    mem_reg_write_data = wdata;
    mem_reg_write_addr = 5'd7;
    mem_reg_write_en   = 1'b1;
  endtask

  task automatic drive_nop();
    mem_aluop          = ALU_NOP;
    mem_mem_addr       = 32'h0;
    mem_store_data     = 32'h0;
    mem_reg_write_data = 32'h0;
    mem_reg_write_addr = 5'd0;
    mem_reg_write_en   = 1'b0;
  endtask

  task automatic check_req(input string tag);
    check({tag, "_req_valid"}, {31'h0, dram_req_valid}, 32'h1);
    check({tag, "_we"},        {31'h0, dram_we}, {31'h0, sb[0].we});
    check({tag, "_addr"},      dram_addr, sb[0].addr);
    check({tag, "_wstrb"},     {28'h0, dram_wstrb}, {28'h0, sb[0].wstrb});
    if (sb[0].chk_wdata) check({tag, "_wdata"}, dram_wdata, sb[0].wdata);
  endtask

  // One full access: issue, optional ready delay, immediate response,
  // optional pause[4] hold in DONE, then the instruction leaves the stage.
  task automatic do_mem(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata,
                        input int ready_dly, input int hold, input exp_t e);
    int   pc;
    int   n;
    exp_t got;
    @(posedge clk); #1;
    drive(op, addr, sdata, 32'hCAFE0000);
    sb.push_back(e);
    pc = 0;
    @(negedge clk);
    if (pause_request_mem) pc++;
    check({tag, "_idle_no_req"}, {31'h0, dram_req_valid}, 32'h0);
    n = 0;
    while (!dram_req_valid && n < 8) begin
      @(negedge clk);
      if (pause_request_mem) pc++;
      n++;
    end
    for (int i = 0; i < ready_dly; i++) begin
      check_req({tag, "_hold"});
      @(negedge clk);
      if (pause_request_mem) pc++;
    end
    check_req(tag);
    dram_req_ready = 1'b1;
    @(posedge clk); #1;
    dram_req_ready  = 1'b0;
    dram_resp_valid = 1'b1;
    dram_rdata      = rdata;
    @(negedge clk);
    if (pause_request_mem) pc++;
    check({tag, "_wait_no_req"}, {31'h0, dram_req_valid}, 32'h0);
    @(posedge clk); #1;
    dram_resp_valid = 1'b0;
    dram_rdata      = 32'hDEADBEEF;
    pause_vec[4]    = (hold > 0);
    @(negedge clk);
    got = sb.pop_front();
    check({tag, "_pause_cycles"}, pc, 3 + ready_dly);
    check({tag, "_done_pause"}, {31'h0, pause_request_mem}, 32'h0);
    check({tag, "_wb_en"}, {31'h0, wb_reg_write_en}, {31'h0, got.wb_en});
    if (got.wb_en) check({tag, "_wb_data"}, wb_reg_write_data, got.wb_data);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (i == hold - 1) pause_vec[4] = 1'b0;
      @(negedge clk);
      check({tag, "_held_no_req"}, {31'h0, dram_req_valid}, 32'h0);
      check({tag, "_held_pause"}, {31'h0, pause_request_mem}, 32'h0);
      if (got.wb_en) check({tag, "_held_wb_data"}, wb_reg_write_data, got.wb_data);
    end
    @(posedge clk); #1;
    drive_nop();
  endtask

  initial begin
    exp_t e;
    rst             = 1'b1;
    pause_vec       = 6'h0;
    dram_req_ready  = 1'b0;
    dram_resp_valid = 1'b0;
    dram_rdata      = 32'h0;
    drive_nop();

    // Reset state
    #2;
    check("rst_req_valid", {31'h0, dram_req_valid}, 32'h0);
    check("rst_we",        {31'h0, dram_we}, 32'h0);
    check("rst_addr",      dram_addr, 32'h0);
    check("rst_wstrb",     {28'h0, dram_wstrb}, 32'h0);
    check("rst_wdata",     dram_wdata, 32'h0);
    check("rst_pause",     {31'h0, pause_request_mem}, 32'h0);
    check("rst_ale",       {31'h0, excp_ale}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Non-memory op passes straight through
    @(posedge clk); #1;
    mem_aluop = ALU_ADD; mem_reg_write_data = 32'h1234;
    mem_reg_write_addr = 5'd5; mem_reg_write_en = 1'b1; mem_mem_addr = 32'h1234;
    @(negedge clk);
    check("add_wb_data",   wb_reg_write_data, 32'h1234);
    check("add_wb_addr",   {27'h0, wb_reg_write_addr}, 32'd5);
    check("add_wb_en",     {31'h0, wb_reg_write_en}, 32'h1);
    check("add_req_valid", {31'h0, dram_req_valid}, 32'h0);
    check("add_pause",     {31'h0, pause_request_mem}, 32'h0);

    // LDB at byte 3, sign-extended
    e = '{we:1'b0, addr:32'h1000, wstrb:4'h0, wdata:32'h0, chk_wdata:1'b0,
          wb_en:1'b1, wb_data:32'hFFFFFF80};
    do_mem("ldb", ALU_LDB, 32'h1003, 32'h0, 32'h80FFFFFF, 0, 0, e);

    // STH upper half, ready delayed 4 cycles
    e = '{we:1'b1, addr:32'h2000, wstrb:4'hC, wdata:32'hABCDABCD, chk_wdata:1'b1,
          wb_en:1'b0, wb_data:32'h0};
    do_mem("sth", ALU_STH, 32'h2002, 32'h0000ABCD, 32'h0, 4, 0, e);

    // Misaligned LDW
    @(posedge clk); #1;
    drive(ALU_LDW, 32'h3001, 32'h0, 32'h0);
    @(negedge clk);
    check("mis_ale",       {31'h0, excp_ale}, 32'h1);
    check("mis_badv",      excp_badv, 32'h3001);
    check("mis_req_valid", {31'h0, dram_req_valid}, 32'h0);
    check("mis_pause",     {31'h0, pause_request_mem}, 32'h0);
    check("mis_wb_en",     {31'h0, wb_reg_write_en}, 32'h0);
    @(negedge clk);
    check("mis_req_later", {31'h0, dram_req_valid}, 32'h0);
    @(posedge clk); #1;
    drive(ALU_LDH, 32'h3003, 32'h0, 32'h0);
    @(negedge clk);
    check("mis_ldh_ale",  {31'h0, excp_ale}, 32'h1);
    check("mis_ldh_badv", excp_badv, 32'h3003);
    @(posedge clk); #1;
    drive_nop();
    @(negedge clk);
    check("nop_ale",  {31'h0, excp_ale}, 32'h0);
    check("nop_badv", excp_badv, 32'h0);

    // LDHU upper half, later stage holds pause[4] for 2 extra cycles
    e = '{we:1'b0, addr:32'h4000, wstrb:4'h0, wdata:32'h0, chk_wdata:1'b0,
          wb_en:1'b1, wb_data:32'h0000BEEF};
    do_mem("ldhu", ALU_LDHU, 32'h4002, 32'h0, 32'hBEEF1234, 0, 2, e);

    // STB at byte 1
    e = '{we:1'b1, addr:32'h7000, wstrb:4'h2, wdata:32'h55555555, chk_wdata:1'b1,
          wb_en:1'b0, wb_data:32'h0};
    do_mem("stb", ALU_STB, 32'h7001, 32'h00000055, 32'h0, 1, 0, e);

    // LDH lower half, sign-extended
    e = '{we:1'b0, addr:32'h8000, wstrb:4'h0, wdata:32'h0, chk_wdata:1'b0,
          wb_en:1'b1, wb_data:32'hFFFF8001};
    do_mem("ldh", ALU_LDH, 32'h8000, 32'h0, 32'h12348001, 0, 0, e);

    // Reset while in WAIT, then a stray response
    @(posedge clk); #1;
    drive(ALU_LDW, 32'h5000, 32'h0, 32'h0);
    @(negedge clk); @(negedge clk);
    check("rw_req_valid", {31'h0, dram_req_valid}, 32'h1);
    dram_req_ready = 1'b1;
    @(posedge clk); #1;
    dram_req_ready = 1'b0;
    @(negedge clk);
    check("rw_wait_pause", {31'h0, pause_request_mem}, 32'h1);
    #1;
    rst = 1'b1;
    drive_nop();
    #1;
    check("rw_rst_req_valid", {31'h0, dram_req_valid}, 32'h0);
    check("rw_rst_addr",      dram_addr, 32'h0);
    check("rw_rst_pause",     {31'h0, pause_request_mem}, 32'h0);
    dram_resp_valid = 1'b1;
    dram_rdata      = 32'hBADBAD00;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    dram_resp_valid = 1'b0;
    @(negedge clk);
    check("rw_stray_req_valid", {31'h0, dram_req_valid}, 32'h0);
    e = '{we:1'b0, addr:32'h6000, wstrb:4'h0, wdata:32'h0, chk_wdata:1'b0,
          wb_en:1'b1, wb_data:32'h11223344};
    do_mem("ldw", ALU_LDW, 32'h6000, 32'h0, 32'h11223344, 0, 0, e);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
